// File: rtl/game_pkg.sv
// Shared state encoding and the level/speed rules used by the flash sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    ON    = 3'd3,
    OFF   = 3'd4,
    DONE  = 3'd5
  } state_e;

  function automatic int unsigned seq_len(input logic [1:0] level,
                                          input int unsigned len_base,
                                          input int unsigned len_step);
    return len_base + len_step * 32'(level);
  endfunction

  function automatic int unsigned on_ticks(input logic [1:0] speed,
                                           input int unsigned base_ticks);
    return base_ticks >> speed;
  endfunction

  // A zero-length blank would wrap the down-counter, so the gap never drops below one tick.
  function automatic int unsigned off_ticks(input logic [1:0] speed,
                                            input int unsigned base_ticks);
    int unsigned off;
    off = on_ticks(speed, base_ticks) >> 1;
    return (off == 0) ? 1 : off;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable tick-enabled down-counter; expired is high while the count sits at zero.
module tick_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/sequence_flash_ctrl.sv
// Reads the stored digit sequence and flashes each digit on the leftmost display
// with tick-timed ON/OFF intervals; reports busy/done to the game FSM.
module sequence_flash_ctrl
  import game_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned BASE_TICKS = 16,
  parameter int unsigned LEN_BASE   = 4,
  parameter int unsigned LEN_STEP   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        levelNumber,
  input  logic [1:0]        speedNumber,
  output logic [ADDR_W-1:0] seq_addr,
  output logic              seq_rd,
  input  logic [3:0]        seq_data,
  output logic [3:0]        numToFlash,
  output logic              noNumToFlash,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = $clog2(BASE_TICKS);

  if (seq_len(2'd3, LEN_BASE, LEN_STEP) > (32'd1 << ADDR_W)) begin : g_len_chk
    $error("sequence_flash_ctrl: longest sequence exceeds sequence RAM depth");
  end
  if ((BASE_TICKS < 8) || ((BASE_TICKS & (BASE_TICKS - 1)) != 0)) begin : g_ticks_chk
    $error("sequence_flash_ctrl: BASE_TICKS must be a power of two >= 8");
  end

  state_e            state_q, state_d;
  logic              entry_q;
  logic [ADDR_W-1:0] idx_q, idx_d, last_q, last_d;
  logic [CW-1:0]     on_m1_q, on_m1_d, off_m1_q, off_m1_d;

  logic              seq_rd_q, seq_rd_d;
  logic [ADDR_W-1:0] seq_addr_q, seq_addr_d;
  logic [3:0]        num_q, num_d;
  logic              nonum_q, nonum_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tmr_load, tmr_expired, interval_end;
  logic [CW-1:0]     tmr_val;

  // Timer reloads in the first cycle of ON/OFF, so a tick in that cycle is never counted.
  assign tmr_load     = entry_q && ((state_q == ON) || (state_q == OFF));
  assign tmr_val      = (state_q == ON) ? on_m1_q : off_m1_q;
  assign interval_end = tick && !entry_q && tmr_expired;

  tick_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      entry_q    <= 1'b0;
      seq_rd_q   <= 1'b0;
      seq_addr_q <= '0;
      num_q      <= '0;
      nonum_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= (state_d != state_q);
      seq_rd_q   <= seq_rd_d;
      seq_addr_q <= seq_addr_d;
      num_q      <= num_d;
      nonum_q    <= nonum_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      last_q   <= '0;
      on_m1_q  <= '0;
      off_m1_q <= '0;
    end else begin
      idx_q    <= idx_d;
      last_q   <= last_d;
      on_m1_q  <= on_m1_d;
      off_m1_q <= off_m1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    on_m1_d  = on_m1_q;
    off_m1_d = off_m1_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = FETCH;
            idx_d    = '0;
            last_d   = ADDR_W'(seq_len(levelNumber, LEN_BASE, LEN_STEP) - 1);
            on_m1_d  = CW'(on_ticks(speedNumber, BASE_TICKS) - 1);
            off_m1_d = CW'(off_ticks(speedNumber, BASE_TICKS) - 1);
          end
        end
        FETCH: state_d = LATCH;
        LATCH: state_d = ON;
        ON: begin
          if (interval_end) state_d = OFF;
        end
        OFF: begin
          if (interval_end) begin
            if (idx_q == last_q) begin
              state_d = DONE;
            end else begin
              state_d = FETCH;
              idx_d   = idx_q + ADDR_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode the next state so every port is a flop aligned with its state.
  always_comb begin
    seq_rd_d   = (state_d == FETCH);
    seq_addr_d = (state_d == FETCH) ? idx_d : seq_addr_q;
    num_d      = (state_q == LATCH) ? seq_data : num_q;
    nonum_d    = (state_d != ON);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  assign seq_rd       = seq_rd_q;
  assign seq_addr     = seq_addr_q;
  assign numToFlash   = num_q;
  assign noNumToFlash = nonum_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sequence_flash_ctrl.sv
// Bench for sequence_flash_ctrl: table of runs plus abort and async-reset sequences.
module tb_sequence_flash_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start, abort;
  logic [1:0] levelNumber, speedNumber;
  logic [3:0] seq_addr;
  logic       seq_rd;
  logic [3:0] seq_data = 4'd0;
  logic [3:0] numToFlash;
  logic       noNumToFlash, busy, done;

  always #5 clk = ~clk;

  sequence_flash_ctrl #(
    .ADDR_W     (4),
    .BASE_TICKS (16),
    .LEN_BASE   (4),
    .LEN_STEP   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .start        (start),
    .abort        (abort),
    .levelNumber  (levelNumber),
    .speedNumber  (speedNumber),
    .seq_addr     (seq_addr),
    .seq_rd       (seq_rd),
    .seq_data     (seq_data),
    .numToFlash   (numToFlash),
    .noNumToFlash (noNumToFlash),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [1:0]  level;
    logic [1:0]  speed;
    logic [63:0] img;
    int          len;
    int          on_t;
    int          off_t;
  } vec_t;

  typedef struct {
    logic [3:0] digit;
    int         on_t;
    int         off_t;
  } flash_t;

  int checks = 0;
  int failures = 0;

  logic [3:0] ram [16];
  logic [3:0] addr_q [$];
  flash_t     flash_q [$];

  int win_cnt = 0, done_cnt = 0;
  bit in_on = 0, in_gap = 0, prev_nonum = 1, prev_done = 0;
  int on_age = 0, on_cnt = 0, gap_age = 0, gap_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (seq_rd) seq_data <= ram[seq_addr];
  end

  // Tick every third cycle, changing just after the edge.
  initial begin
    int tcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      tick = (tcnt == 0);
      tcnt = (tcnt == 2) ? 0 : tcnt + 1;
    end
  end

  // Monitor: measures ON/OFF tick counts per entry and pops the scoreboard.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      in_on = 0; in_gap = 0; prev_nonum = 1; prev_done = 0;
    end else begin
      if (seq_rd) begin
        if (addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read actual=%0d required=none", seq_addr);
        end else begin
          chk("read_addr", int'(seq_addr), int'(addr_q.pop_front()));
        end
      end
      if (!prev_nonum && in_on) begin
        if (on_age > 0 && tick) on_cnt++;
        on_age++;
      end
      if (in_gap) begin
        if (gap_age > 0 && tick) gap_cnt++;
        gap_age++;
      end
      if (prev_nonum && !noNumToFlash) begin
        in_on = 1; on_age = 0; on_cnt = 0; win_cnt++;
      end
      if (!prev_nonum && noNumToFlash) begin
        in_on = 0;
        if (busy) begin in_gap = 1; gap_age = 0; gap_cnt = 0; end
      end
      if (in_gap && !busy) in_gap = 0;
      if (in_gap && (seq_rd || done)) begin
        in_gap = 0;
        if (flash_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_flash actual=%0d required=none", numToFlash);
        end else begin
          flash_t r;
          r = flash_q.pop_front();
          chk("flash_digit", int'(numToFlash), int'(r.digit));
          chk("on_ticks", on_cnt, r.on_t);
          chk("off_ticks", gap_cnt, r.off_t);
        end
      end
      if (done) done_cnt++;
      if (prev_done) chk("busy_after_done", int'(busy), 0);
      prev_nonum = noNumToFlash;
      prev_done  = done;
    end
  end

  task automatic arm(input vec_t v);
    for (int i = 0; i < 16; i++) ram[i] = v.img[4*i +: 4];
    addr_q.delete();
    flash_q.delete();
    for (int i = 0; i < v.len; i++) begin
      addr_q.push_back(4'(i));
      flash_q.push_back('{v.img[4*i +: 4], v.on_t, v.off_t});
    end
    levelNumber = v.level;
    speedNumber = v.speed;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, w0, d0;
    bit seen;
    w0 = win_cnt; d0 = done_cnt;
    arm(v);
    cyc = 0; seen = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 20) begin
        start = 1'b1;
        levelNumber = ~v.level;
        speedNumber = ~v.speed;
      end
      if (done) begin seen = 1; start = 1'b1; end
    end
    chk("done_seen", int'(seen), 1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_idle_after_done", int'(busy), 0);
    repeat (4) begin
      @(negedge clk);
      chk("stays_idle", int'(busy), 0);
    end
    chk("reads_left", addr_q.size(), 0);
    chk("flashes_left", flash_q.size(), 0);
    chk("on_windows", win_cnt - w0, v.len);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  vec_t vecs [5];

  initial begin
    int cyc, w0, d0;
    vecs[0] = '{2'd0, 2'd0, 64'hFFFF_FFFF_FFFF_9173, 4, 16, 8};
    vecs[1] = '{2'd3, 2'd3, 64'hEEEE_EE31_96B4_F082, 10, 2, 1};
    vecs[2] = '{2'd0, 2'd0, 64'h0000_0000_0000_5555, 4, 16, 8};
    vecs[3] = '{2'd1, 2'd2, 64'h0000_0000_00A1_E2C4, 6, 4, 2};
    vecs[4] = '{2'd2, 2'd1, 64'h0000_0000_8765_4321, 8, 8, 4};

    start = 1'b0; abort = 1'b0; levelNumber = '0; speedNumber = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_addr", int'(seq_addr), 0);
    chk("rst_rd", int'(seq_rd), 0);
    chk("rst_num", int'(numToFlash), 0);
    chk("rst_nonum", int'(noNumToFlash), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort together with a tick in the second ON window.
    w0 = win_cnt;
    arm(vecs[0]);
    cyc = 0;
    while (!((win_cnt - w0 == 2) && in_on && on_age >= 2 && tick) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_point_reached", int'(cyc < 2000), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    addr_q.delete();
    flash_q.delete();
    chk("abort_nonum", int'(noNumToFlash), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rd", int'(seq_rd), 0);
    d0 = done_cnt;
    repeat (200) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_busy_later", int'(busy), 0);

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", int'(busy), 0);
    @(negedge clk);

    // Async reset in the middle of an OFF gap.
    arm(vecs[3]);
    cyc = 0;
    while (!(in_gap && gap_age >= 1) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("off_gap_reached", int'(cyc < 2000), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", int'(seq_addr), 0);
    chk("arst_rd", int'(seq_rd), 0);
    chk("arst_num", int'(numToFlash), 0);
    chk("arst_nonum", int'(noNumToFlash), 1);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    addr_q.delete();
    flash_q.delete();
    @(negedge clk);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
